// File: rtl/battle_pkg.sv
// Shared widths, lane home positions and the combat-round FSM encoding for the
// battle_front lane resolver.
package battle_pkg;

  localparam int POS_W = 9;
  localparam int DMG_W = 8;

  localparam logic [POS_W-1:0] POS_FRIEND_HOME = 9'h1FF;
  localparam logic [POS_W-1:0] POS_ENEMY_HOME  = 9'h000;

  // One-hot round sequencer: IDLE -> SCAN -> DAMAGE -> MOVE -> IDLE.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_SCAN   = 4'b0010,
    ST_DAMAGE = 4'b0100,
    ST_MOVE   = 4'b1000
  } state_t;

endpackage

// File: rtl/front_scan.sv
// One side's slot scanner: tracks the frontmost alive position (min or max),
// its slot index, a found flag and a saturating sum of all slots' damage.
module front_scan
  import battle_pkg::*;
#(
  parameter int N        = 4,
  parameter bit FIND_MIN = 1'b1,
  localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_scan_en,
  input  logic [IW-1:0]    i_idx,
  input  logic [POS_W-1:0] i_pos,
  input  logic [DMG_W-1:0] i_dmg,
  input  logic             i_dead,
  output logic [POS_W-1:0] o_ext_nxt,
  output logic [IW-1:0]    o_idx_nxt,
  output logic             o_found_nxt,
  output logic [DMG_W-1:0] o_sum_nxt
);

  logic [POS_W-1:0] r_ext;
  logic [IW-1:0]    r_idx;
  logic             r_found;
  logic [DMG_W-1:0] r_sum;

  logic             w_better;
  logic             w_take;
  logic [DMG_W:0]   w_sum_wide;

  // Strict compare keeps the lowest index on ties; the found flag lets a unit
  // sitting exactly on the home edge still be captured.
  always_comb begin
    w_better    = FIND_MIN ? (i_pos < r_ext) : (i_pos > r_ext);
    w_take      = i_scan_en && !i_dead && (!r_found || w_better);
    w_sum_wide  = {1'b0, r_sum} + {1'b0, i_dmg};
    o_ext_nxt   = r_ext;
    o_idx_nxt   = r_idx;
    o_found_nxt = r_found;
    o_sum_nxt   = r_sum;
    if (w_take) begin
      o_ext_nxt   = i_pos;
      o_idx_nxt   = i_idx;
      o_found_nxt = 1'b1;
    end
    if (i_scan_en) begin
      o_sum_nxt = w_sum_wide[DMG_W] ? {DMG_W{1'b1}} : w_sum_wide[DMG_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ext   <= '0;
      r_idx   <= '0;
      r_found <= 1'b0;
      r_sum   <= '0;
    end else if (i_clear) begin
      r_ext   <= '0;
      r_idx   <= '0;
      r_found <= 1'b0;
      r_sum   <= '0;
    end else begin
      r_ext   <= o_ext_nxt;
      r_idx   <= o_idx_nxt;
      r_found <= o_found_nxt;
      r_sum   <= o_sum_nxt;
    end
  end

endmodule

// File: rtl/battle_front.sv
// Lane combat resolver: scans both unit arrays each round, routes damage to the
// opposing front unit, strobes damage/move, grants spawns and latches breaches.
// Optional spawn lockout is enabled by defining SPAWN_COOLDOWN_EN.
module battle_front
  import battle_pkg::*;
#(
  parameter int N        = 4,
  parameter int TICK_DIV = 1024,
  parameter int COOLDOWN = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [POS_W*N-1:0] friend_pos,
  input  logic [DMG_W*N-1:0] friend_dmg,
  input  logic [N-1:0]       friend_dead,
  input  logic [POS_W*N-1:0] enemy_pos,
  input  logic [DMG_W*N-1:0] enemy_dmg,
  input  logic [N-1:0]       enemy_dead,
  input  logic               spawn_req,
  output logic               move_scen,
  output logic               damage_scen,
  output logic [DMG_W*N-1:0] dmg_to_friend,
  output logic [DMG_W*N-1:0] dmg_to_enemy,
  output logic [POS_W-1:0]   enemy_front,
  output logic [POS_W-1:0]   friend_front,
  output logic [N-1:0]       can_spawn,
  output logic               enemy_breach,
  output logic               friend_breach,
  output logic [3:0]         dbg_state
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [IW-1:0] SLOT_LAST = IW'(N - 1);

  state_t               r_state;
  logic [TW-1:0]        r_tick;
  logic [IW-1:0]        r_slot;
  logic                 r_move_scen;
  logic                 r_damage_scen;
  logic [DMG_W*N-1:0]   r_dmg_to_friend;
  logic [DMG_W*N-1:0]   r_dmg_to_enemy;
  logic [POS_W-1:0]     r_enemy_front;
  logic [POS_W-1:0]     r_friend_front;
  logic [N-1:0]         r_can_spawn;
  logic                 r_enemy_breach;
  logic                 r_friend_breach;

  logic                 w_clear;
  logic                 w_scan_en;
  logic [POS_W-1:0]     w_f_ext, w_e_ext;
  logic [IW-1:0]        w_f_idx, w_e_idx;
  logic                 w_f_found, w_e_found;
  logic [DMG_W-1:0]     w_f_sum, w_e_sum;
  logic [DMG_W*N-1:0]   w_dmg_f, w_dmg_e;
  logic [N-1:0]         w_spawn_onehot;
  logic                 w_spawn_lock;

  assign w_clear   = (r_state == ST_IDLE) && (r_tick == TICK_LAST);
  assign w_scan_en = (r_state == ST_SCAN);

  front_scan #(.N(N), .FIND_MIN(1'b1)) u_friend_scan (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_clear),
    .i_scan_en   (w_scan_en),
    .i_idx       (r_slot),
    .i_pos       (friend_pos[POS_W*r_slot +: POS_W]),
    .i_dmg       (friend_dmg[DMG_W*r_slot +: DMG_W]),
    .i_dead      (friend_dead[r_slot]),
    .o_ext_nxt   (w_f_ext),
    .o_idx_nxt   (w_f_idx),
    .o_found_nxt (w_f_found),
    .o_sum_nxt   (w_f_sum)
  );

  front_scan #(.N(N), .FIND_MIN(1'b0)) u_enemy_scan (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_clear),
    .i_scan_en   (w_scan_en),
    .i_idx       (r_slot),
    .i_pos       (enemy_pos[POS_W*r_slot +: POS_W]),
    .i_dmg       (enemy_dmg[DMG_W*r_slot +: DMG_W]),
    .i_dead      (enemy_dead[r_slot]),
    .o_ext_nxt   (w_e_ext),
    .o_idx_nxt   (w_e_idx),
    .o_found_nxt (w_e_found),
    .o_sum_nxt   (w_e_sum)
  );

  // Each side is hit by the other side's total damage, at its own front slot.
  always_comb begin
    w_dmg_f = '0;
    w_dmg_e = '0;
    if (w_f_found) w_dmg_f[DMG_W*w_f_idx +: DMG_W] = w_e_sum;
    if (w_e_found) w_dmg_e[DMG_W*w_e_idx +: DMG_W] = w_f_sum;
  end

  assign w_spawn_onehot = friend_dead & (~friend_dead + N'(1));

`ifdef SPAWN_COOLDOWN_EN
  localparam int CW = $clog2(COOLDOWN + 1);
  logic [CW-1:0] r_cool;
  logic [CW-1:0] w_cool_nxt;
  logic          r_spawn_req_d;

  always_comb begin
    w_cool_nxt = (r_cool != '0) ? r_cool - CW'(1) : '0;
    if (spawn_req && !r_spawn_req_d && (r_can_spawn != '0)) w_cool_nxt = CW'(COOLDOWN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cool        <= '0;
      r_spawn_req_d <= 1'b0;
    end else begin
      r_cool        <= w_cool_nxt;
      r_spawn_req_d <= spawn_req;
    end
  end

  assign w_spawn_lock = (w_cool_nxt != '0);
`else
  assign w_spawn_lock = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_can_spawn <= '0;
    end else begin
      r_can_spawn <= w_spawn_lock ? '0 : w_spawn_onehot;
    end
  end

  // Round sequencer; strobes and damage buses are registered so they line up
  // exactly with the DAMAGE and MOVE states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_tick          <= '0;
      r_slot          <= '0;
      r_move_scen     <= 1'b0;
      r_damage_scen   <= 1'b0;
      r_dmg_to_friend <= '0;
      r_dmg_to_enemy  <= '0;
      r_enemy_front   <= POS_ENEMY_HOME;
      r_friend_front  <= POS_FRIEND_HOME;
      r_enemy_breach  <= 1'b0;
      r_friend_breach <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_tick == TICK_LAST) begin
            r_tick  <= '0;
            r_slot  <= '0;
            r_state <= ST_SCAN;
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end
        ST_SCAN: begin
          r_slot <= r_slot + IW'(1);
          if (r_slot == SLOT_LAST) begin
            r_state         <= ST_DAMAGE;
            r_damage_scen   <= 1'b1;
            r_dmg_to_friend <= w_dmg_f;
            r_dmg_to_enemy  <= w_dmg_e;
            r_friend_front  <= w_f_found ? w_f_ext : POS_FRIEND_HOME;
            r_enemy_front   <= w_e_found ? w_e_ext : POS_ENEMY_HOME;
            if (w_e_found && (w_e_ext == POS_FRIEND_HOME)) r_enemy_breach  <= 1'b1;
            if (w_f_found && (w_f_ext == POS_ENEMY_HOME))  r_friend_breach <= 1'b1;
          end
        end
        ST_DAMAGE: begin
          r_damage_scen   <= 1'b0;
          r_dmg_to_friend <= '0;
          r_dmg_to_enemy  <= '0;
          r_move_scen     <= 1'b1;
          r_state         <= ST_MOVE;
        end
        ST_MOVE: begin
          r_move_scen <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state         <= ST_IDLE;
          r_tick          <= '0;
          r_move_scen     <= 1'b0;
          r_damage_scen   <= 1'b0;
          r_dmg_to_friend <= '0;
          r_dmg_to_enemy  <= '0;
        end
      endcase
    end
  end

  assign move_scen     = r_move_scen;
  assign damage_scen   = r_damage_scen;
  assign dmg_to_friend = r_dmg_to_friend;
  assign dmg_to_enemy  = r_dmg_to_enemy;
  assign enemy_front   = r_enemy_front;
  assign friend_front  = r_friend_front;
  assign can_spawn     = r_can_spawn;
  assign enemy_breach  = r_enemy_breach;
  assign friend_breach = r_friend_breach;
  assign dbg_state     = r_state;

endmodule

// File: doc/battle_front.md
Name: battle_front

Overview:
Lane combat resolver; the other end of the per-unit interface. It scans all friendly and enemy unit slots and computes each side's frontmost alive position. It routes aggregated attack damage to the opposing front unit and issues the global damage and move strobes. It also grants spawn permission to exactly one free friendly slot and flags base breaches. Sits in top level between the friendly and enemy unit arrays.

Parameters:
N, 4, unit slots per side (friendly and enemy each)
TICK_DIV, 1024, IDLE cycles per combat round (>=2)
COOLDOWN, 64, spawn lockout cycles (optional feature only)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
friend_pos  in  9*N  friendly slot positions, slot i at [9i+:9]; friendlies move toward 0
friend_dmg  in  8*N  friendly damageOut per slot
friend_dead  in  N  friendly dead flags
enemy_pos  in  9*N  enemy positions; enemies move toward 511
enemy_dmg  in  8*N  enemy damageOut per slot
enemy_dead  in  N  enemy dead flags
spawn_req  in  1  OR of player left/right/down buttons
move_scen  out  1  one-cycle move strobe to all units
damage_scen  out  1  one-cycle damage strobe to all units
dmg_to_friend  out  8*N  damageIn per friendly slot
dmg_to_enemy  out  8*N  damageIn per enemy slot
enemy_front  out  9  max alive enemy position, fed to friendlies
friend_front  out  9  min alive friendly position, fed to enemies
can_spawn  out  N  one-hot spawn grant, friendly side
enemy_breach  out  1  sticky: enemy front reached 511
friend_breach  out  1  sticky: friendly front reached 0

Behaviour:
- Reset values: move_scen=0, damage_scen=0, dmg buses all 0, enemy_front=9'h000, friend_front=9'h1FF, can_spawn=0, breaches=0, FSM=IDLE, tick counter=0. Reset mid-round aborts the round with no strobes.
- FSM: IDLE -> SCAN -> DAMAGE -> MOVE -> IDLE.
- IDLE: counter runs 0..TICK_DIV-1; on TICK_DIV-1 clear the counter, clear accumulators, go to SCAN.
- SCAN: N cycles; visits slot k on cycle k.
  - Friendly: if !friend_dead[k] and pos < running min, update min and index.
  - Enemy: if !enemy_dead[k] and pos > running max, update max and index.
  - Strict compare, so ties go to the lowest index.
  - Accumulate sum of friend_dmg and sum of enemy_dmg, each saturating at 255. Dead slots still sum.
- SCAN end: register friend_front (9'h1FF if no friendly alive) and enemy_front (9'h000 if no enemy alive). Both hold until the next SCAN end.
- DAMAGE: one cycle.
  - damage_scen=1.
  - dmg_to_friend[front friendly slot] = enemy sum; dmg_to_enemy[front enemy slot] = friendly sum.
  - No alive unit on the target side: that bus stays all 0.
- Every dmg bus slot is 0 in every cycle except DAMAGE. This is mandatory, because units test health<=damageIn every cycle.
- MOVE: one cycle, move_scen=1, then IDLE.
- Round period = TICK_DIV+N+2 cycles. move_scen and damage_scen are never high together.
- Breaches: set enemy_breach when a registered enemy_front equals 9'h1FF with at least one enemy alive. Set friend_breach when friend_front equals 0 with at least one friendly alive. Clear only on reset. The FSM keeps running.
- can_spawn: registered every cycle as the one-hot of the lowest-index set bit of friend_dead; 0 if none.

Optional Feature:
SPAWN_COOLDOWN_EN.
- Defined: a rising edge of spawn_req while can_spawn!=0 loads a lockout counter with COOLDOWN. can_spawn is forced 0 while the counter is nonzero, which prevents multi-slot spawns from a held button.
- Undefined: spawn_req is ignored, no counter is synthesised, and can_spawn follows the base rule.

Decomposition:
- Package battle_pkg holds:
  - POS_W=9, DMG_W=8.
  - POS_FRIEND_HOME=9'h1FF, POS_ENEMY_HOME=9'h000.
  - The FSM state encoding (one-hot, 4 states).
- Sub-module front_scan: one instance per side, parameterised by compare direction. Each holds its running extremum, index, found flag and saturating damage sum.

Test Plan (N=4, TICK_DIV=8, COOLDOWN=4):
- Reset mid-SCAN: assert reset -> all outputs at reset values next cycle; no strobes until 8 IDLE cycles pass.
- Friendly pos {300,200,200,511}, dead {0,0,0,1}; enemies all dead -> friend_front=200 (slot1), enemy_front=0; dmg_to_enemy all 0; damage_scen then move_scen on consecutive cycles.
- Enemy dmg {200,100,0,0} alive, friendly slot2 front -> dmg_to_friend slot2=255 (saturated) for exactly the DAMAGE cycle; 0 on all other cycles and slots.
- friend_dead=4'b1010 -> can_spawn=4'b0010 one cycle later; dead becomes 4'b1000 -> can_spawn=4'b1000.
- Alive enemy at 511 -> enemy_breach=1 after SCAN end, held through later rounds until reset.
- SPAWN_COOLDOWN_EN with spawn_req held 10 cycles -> can_spawn 0 for 4 cycles after the edge; exactly one grant window per press.
